lpddr2_mr_access_seq: RTL and testbench

- Sequences LPDDR2 Mode Register Write (MRW) and Mode Register Read (MRR) commands for CSR/host software.
- Obtains exclusive command-bus ownership from the main arbiter, then drives a single-cycle do_lmr / do_lmr_read with chip, MA and OP fields into the LPDDR2 address/command decoder.
- Enforces tMRW/tMRR spacing, captures MRR read data and returns a response.
- Sits between the CSR slave and the controller arbiter, beside the address/command decoder.

---
 rtl/lpddr2_mr_access_seq_if.sv | 39 +++
 rtl/lpddr2_mr_access_seq.sv | 157 +++++++++++++++
 tb/tb_lpddr2_mr_access_seq.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/lpddr2_mr_access_seq_if.sv
// lpddr2_mr_access_seq_if: host request/response, arbiter handshake and decoder command bus
// of the LPDDR2 mode-register access sequencer.
interface lpddr2_mr_access_seq_if #(
    parameter int CFG_MEM_IF_CHIP = 1
);
    logic                       ctl_cal_success;
    logic                       cmd_req_valid;
    logic                       cmd_req_ready;
    logic                       cmd_req_read;
    logic [CFG_MEM_IF_CHIP-1:0] cmd_req_chip;
    logic [7:0]                 cmd_req_ma;
    logic [7:0]                 cmd_req_op;
    logic                       cmd_rsp_valid;
    logic [7:0]                 cmd_rsp_data;
    logic                       cmd_rsp_err;
    logic                       bus_req;
    logic                       bus_gnt;
    logic                       do_lmr;
    logic                       do_lmr_read;
    logic [CFG_MEM_IF_CHIP-1:0] to_chip;
    logic [7:0]                 to_lmr;
    logic [7:0]                 lmr_opcode;
    logic                       mrr_rdata_valid;
    logic [7:0]                 mrr_rdata;

    modport slave (
        input  ctl_cal_success, cmd_req_valid, cmd_req_read, cmd_req_chip, cmd_req_ma, cmd_req_op,
               bus_gnt, mrr_rdata_valid, mrr_rdata,
        output cmd_req_ready, cmd_rsp_valid, cmd_rsp_data, cmd_rsp_err, bus_req, do_lmr,
               do_lmr_read, to_chip, to_lmr, lmr_opcode
    );

    modport master (
        output ctl_cal_success, cmd_req_valid, cmd_req_read, cmd_req_chip, cmd_req_ma, cmd_req_op,
               bus_gnt, mrr_rdata_valid, mrr_rdata,
        input  cmd_req_ready, cmd_rsp_valid, cmd_rsp_data, cmd_rsp_err, bus_req, do_lmr,
               do_lmr_read, to_chip, to_lmr, lmr_opcode
    );
endinterface

// File: rtl/lpddr2_mr_access_seq.sv
// lpddr2_mr_access_seq: sequences LPDDR2 MRW/MRR commands with tMRW/tMRR spacing and MRR capture.
// Optional MRR data timeout enabled by defining LPDDR2_MRR_TIMEOUT_EN.
module lpddr2_mr_access_seq #(
    parameter int CFG_MEM_IF_CHIP = 1,
    parameter int CFG_TMRW        = 5,
    parameter int CFG_TMRR        = 2,
    parameter int CFG_MRR_TIMEOUT = 63
) (
    input  logic                         ctl_clk,
    input  logic                         ctl_reset_n,
    lpddr2_mr_access_seq_if.slave        io_mr
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    if (CFG_TMRW < 1 || CFG_TMRW > 255 || CFG_TMRR < 1 || CFG_TMRR > 255 ||
        CFG_MRR_TIMEOUT < 1 || CFG_MRR_TIMEOUT > 255) begin : g_bad_cfg
        $error("lpddr2_mr_access_seq: timing parameter outside 1..255");
    end

    logic [2:0]                 r_state;
    logic                       r_read;
    logic [CFG_MEM_IF_CHIP-1:0] r_chip;
    logic [7:0]                 r_ma;
    logic [7:0]                 r_op;
    logic [7:0]                 r_cnt;
    logic                       r_cap;
    logic [7:0]                 r_data;
    logic                       r_ready;
    logic                       r_rsp_valid;
    logic [7:0]                 r_rsp_data;
    logic                       r_rsp_err;
    logic                       r_bus_req;
    logic                       r_do_lmr;
    logic                       r_do_lmr_read;
    logic [CFG_MEM_IF_CHIP-1:0] r_to_chip;
    logic [7:0]                 r_to_lmr;
    logic [7:0]                 r_lmr_opcode;

    logic [2:0] w_next;
    logic       w_err;
    logic       w_tout;
    logic       w_drv;
    logic       w_have;
    logic [7:0] w_rsp_data;

    // Data strobe in the exit cycle counts as captured so the response follows it directly.
    assign w_have     = r_cap || io_mr.mrr_rdata_valid;
    assign w_drv      = (w_next == S_ISSUE) || (w_next == S_WAIT);
    assign w_rsp_data = (r_state == S_WAIT && r_read && !w_err) ?
                        (r_cap ? r_data : io_mr.mrr_rdata) : 8'h00;

`ifdef LPDDR2_MRR_TIMEOUT_EN
    logic [7:0] r_tcnt;
    always_ff @(posedge ctl_clk or negedge ctl_reset_n)
        if (!ctl_reset_n) r_tcnt <= 8'd0;
        else if (r_state == S_REQ) r_tcnt <= 8'(CFG_MRR_TIMEOUT - 1);
        else if (r_tcnt != 8'd0) r_tcnt <= r_tcnt - 8'd1;
    assign w_tout = r_read && !w_have && (r_tcnt == 8'd0);
`else
    assign w_tout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        case (r_state)
            S_IDLE:  w_next = (io_mr.cmd_req_valid && r_ready) ? S_CHECK : S_IDLE;
            S_CHECK: begin
                w_err  = !(|r_chip) || (r_read && !$onehot(r_chip));
                w_next = w_err ? S_RESP : S_REQ;
            end
            S_REQ: begin
                w_err  = !io_mr.ctl_cal_success;
                w_next = w_err ? S_RESP : (io_mr.bus_gnt ? S_ISSUE : S_REQ);
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                w_err  = w_tout;
                w_next = (w_tout || (r_cnt == 8'd0 && (!r_read || w_have))) ? S_RESP : S_WAIT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            r_state <= S_IDLE;
            r_read  <= 1'b0;
            r_chip  <= '0;
            r_ma    <= 8'h00;
            r_op    <= 8'h00;
            r_cnt   <= 8'd0;
            r_cap   <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_next == S_CHECK) begin
                r_read <= io_mr.cmd_req_read;
                r_chip <= io_mr.cmd_req_chip;
                r_ma   <= io_mr.cmd_req_ma;
                r_op   <= io_mr.cmd_req_op;
                r_cap  <= 1'b0;
            end else if ((r_state == S_ISSUE || r_state == S_WAIT) && io_mr.mrr_rdata_valid && !r_cap) begin
                r_cap  <= 1'b1;
                r_data <= io_mr.mrr_rdata;
            end
            // Loaded while in REQ so ISSUE already holds tMRx-1; saturates at zero afterwards.
            if (r_state == S_REQ)
                r_cnt <= r_read ? 8'(CFG_TMRR - 1) : 8'(CFG_TMRW - 1);
            else if (r_cnt != 8'd0)
                r_cnt <= r_cnt - 8'd1;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            r_ready       <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= 8'h00;
            r_rsp_err     <= 1'b0;
            r_bus_req     <= 1'b0;
            r_do_lmr      <= 1'b0;
            r_do_lmr_read <= 1'b0;
            r_to_chip     <= '0;
            r_to_lmr      <= 8'h00;
            r_lmr_opcode  <= 8'h00;
        end else begin
            r_ready       <= (w_next == S_IDLE) && io_mr.ctl_cal_success;
            r_rsp_valid   <= w_next == S_RESP;
            r_rsp_data    <= (w_next == S_RESP) ? w_rsp_data : 8'h00;
            r_rsp_err     <= w_err;
            r_bus_req     <= (w_next == S_REQ) || w_drv;
            r_do_lmr      <= (w_next == S_ISSUE) && !r_read;
            r_do_lmr_read <= (w_next == S_ISSUE) && r_read;
            r_to_chip     <= w_drv ? r_chip : '0;
            r_to_lmr      <= w_drv ? r_ma : 8'h00;
            r_lmr_opcode  <= (w_drv && !r_read) ? r_op : 8'h00;
        end
    end

    assign io_mr.cmd_req_ready = r_ready;
    assign io_mr.cmd_rsp_valid = r_rsp_valid;
    assign io_mr.cmd_rsp_data  = r_rsp_data;
    assign io_mr.cmd_rsp_err   = r_rsp_err;
    assign io_mr.bus_req       = r_bus_req;
    assign io_mr.do_lmr        = r_do_lmr;
    assign io_mr.do_lmr_read   = r_do_lmr_read;
    assign io_mr.to_chip       = r_to_chip;
    assign io_mr.to_lmr        = r_to_lmr;
    assign io_mr.lmr_opcode    = r_lmr_opcode;
endmodule

// File: tb/tb_lpddr2_mr_access_seq.sv
// tb_lpddr2_mr_access_seq: table-driven MRW/MRR transactions plus reset and calibration sequences.
module tb_lpddr2_mr_access_seq;
    logic ctl_clk = 1'b0;
    logic ctl_reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errs = 0;

    lpddr2_mr_access_seq_if #(.CFG_MEM_IF_CHIP(2)) m ();

    lpddr2_mr_access_seq #(
        .CFG_MEM_IF_CHIP(2), .CFG_TMRW(5), .CFG_TMRR(2), .CFG_MRR_TIMEOUT(63)
    ) dut (
        .ctl_clk(ctl_clk), .ctl_reset_n(ctl_reset_n), .io_mr(m)
    );

    always #5 ctl_clk = ~ctl_clk;

    typedef struct {
        logic       rd;
        logic [1:0] chip;
        logic [7:0] ma, op, rdata;
        int         gnt_dly, dat_dly, drop_at;
        bit         early, extra;
        int         e_issue, e_rsp, e_nbus;
        logic       e_err;
        logic [7:0] e_data, e_opc;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge ctl_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {m.cmd_req_ready, m.cmd_rsp_valid, m.cmd_rsp_data, m.cmd_rsp_err, m.bus_req,
                m.do_lmr, m.do_lmr_read, m.to_chip, m.to_lmr, m.lmr_opcode};
    endfunction

    task automatic run(input int idx, input vec_t v);
        int c = 1, fb = 0, iss = 0, rspc = 0, nbus = 0, nl = 0, nlr = 0;
        logic [1:0] s_chip = '0, r_chip = '0;
        logic [7:0] s_ma = '0, s_op = '0, r_data = '0;
        logic r_err = 1'b0, r_bus = 1'b0;
        string p = $sformatf("v%0d", idx);
        for (int k = 0; k < 20 && !m.cmd_req_ready; k++) tick();
        check({p, "_ready"}, 32'(m.cmd_req_ready), 32'd1);
        m.cmd_req_valid = 1'b1;
        m.cmd_req_read = v.rd;
        m.cmd_req_chip = v.chip;
        m.cmd_req_ma = v.ma;
        m.cmd_req_op = v.op;
        tick();
        m.cmd_req_valid = 1'b0;
        while (c < 200 && rspc == 0) begin
            if (m.bus_req) begin
                nbus++;
                if (fb == 0) fb = c;
            end
            if (m.do_lmr || m.do_lmr_read) begin
                nl += int'(m.do_lmr);
                nlr += int'(m.do_lmr_read);
                if (iss == 0) iss = c;
                s_chip = m.to_chip;
                s_ma = m.to_lmr;
                s_op = m.lmr_opcode;
            end
            if (m.cmd_rsp_valid) begin
                rspc = c;
                r_err = m.cmd_rsp_err;
                r_data = m.cmd_rsp_data;
                r_bus = m.bus_req;
                r_chip = m.to_chip;
                m.bus_gnt = 1'b0;
                m.ctl_cal_success = 1'b1;
                m.mrr_rdata_valid = 1'b0;
            end else begin
                m.ctl_cal_success = !(v.drop_at != 0 && c >= v.drop_at);
                m.bus_gnt = (iss == 0) && (fb != 0) && (c >= fb + v.gnt_dly);
                m.mrr_rdata_valid = 1'b0;
                if (iss != 0 && c == iss + v.dat_dly) begin
                    m.mrr_rdata_valid = 1'b1;
                    m.mrr_rdata = v.rdata;
                end
                if (v.extra && iss != 0 && c == iss + v.dat_dly + 1) begin
                    m.mrr_rdata_valid = 1'b1;
                    m.mrr_rdata = ~v.rdata;
                end
                if (v.early && c == 1) begin
                    m.mrr_rdata_valid = 1'b1;
                    m.mrr_rdata = 8'hC3;
                end
            end
            tick();
            c++;
        end
        check({p, "_rsp_cycle"}, 32'(rspc), 32'(v.e_rsp));
        check({p, "_rsp_err"}, 32'(r_err), 32'(v.e_err));
        check({p, "_rsp_data"}, 32'(r_data), 32'(v.e_data));
        check({p, "_issue_cycle"}, 32'(iss), 32'(v.e_issue));
        check({p, "_n_do_lmr"}, 32'(nl), 32'(v.e_issue != 0 && !v.rd));
        check({p, "_n_do_lmr_read"}, 32'(nlr), 32'(v.e_issue != 0 && v.rd));
        check({p, "_bus_req_cycles"}, 32'(nbus), 32'(v.e_nbus));
        check({p, "_bus_req_at_rsp"}, 32'(r_bus), 32'd0);
        check({p, "_to_chip_at_rsp"}, 32'(r_chip), 32'd0);
        check({p, "_rsp_one_cycle"}, 32'(m.cmd_rsp_valid), 32'd0);
        check({p, "_ready_after_rsp"}, 32'(m.cmd_req_ready), 32'd1);
        if (v.e_issue != 0) begin
            check({p, "_to_chip"}, 32'(s_chip), 32'(v.chip));
            check({p, "_to_lmr"}, 32'(s_ma), 32'(v.ma));
            check({p, "_lmr_opcode"}, 32'(s_op), 32'(v.e_opc));
        end
    endtask

    initial begin
        // rd chip ma op rdata gnt dat drop early extra | issue rsp nbus err data opc
        vecs[0] = '{1'b0, 2'b01, 8'h0A, 8'hFF, 8'h00, 2,    1000, 0, 1'b0, 1'b0, 5, 10, 8,  1'b0, 8'h00, 8'hFF};
        vecs[1] = '{1'b1, 2'b01, 8'h05, 8'h77, 8'h13, 0,    1,    0, 1'b0, 1'b0, 3, 5,  3,  1'b0, 8'h13, 8'h00};
        vecs[2] = '{1'b1, 2'b01, 8'h05, 8'h00, 8'h5A, 0,    10,   0, 1'b1, 1'b0, 3, 14, 12, 1'b0, 8'h5A, 8'h00};
        vecs[3] = '{1'b1, 2'b01, 8'h06, 8'h00, 8'h21, 0,    0,    0, 1'b0, 1'b1, 3, 5,  3,  1'b0, 8'h21, 8'h00};
        vecs[4] = '{1'b1, 2'b11, 8'h05, 8'h00, 8'h00, 0,    1,    0, 1'b0, 1'b0, 0, 2,  0,  1'b1, 8'h00, 8'h00};
        vecs[5] = '{1'b0, 2'b11, 8'h01, 8'h3C, 8'h00, 0,    1000, 0, 1'b0, 1'b0, 3, 8,  6,  1'b0, 8'h00, 8'h3C};
        vecs[6] = '{1'b0, 2'b00, 8'h01, 8'h3C, 8'h00, 0,    1000, 0, 1'b0, 1'b0, 0, 2,  0,  1'b1, 8'h00, 8'h00};
        vecs[7] = '{1'b0, 2'b01, 8'h0B, 8'h12, 8'h00, 1000, 1000, 4, 1'b0, 1'b0, 0, 5,  3,  1'b1, 8'h00, 8'h00};
        vecs[8] = '{1'b1, 2'b10, 8'h08, 8'h00, 8'hA5, 1,    2,    5, 1'b0, 1'b0, 4, 7,  5,  1'b0, 8'hA5, 8'h00};

        m.ctl_cal_success = 1'b0;
        m.cmd_req_valid = 1'b0;
        m.cmd_req_read = 1'b0;
        m.cmd_req_chip = '0;
        m.cmd_req_ma = '0;
        m.cmd_req_op = '0;
        m.bus_gnt = 1'b0;
        m.mrr_rdata_valid = 1'b0;
        m.mrr_rdata = '0;
        tick();
        m.ctl_cal_success = 1'b1;
        tick();
        check("reset_outputs", all_out(), 32'd0);
        m.ctl_cal_success = 1'b0;
        ctl_reset_n = 1'b1;
        tick();
        tick();
        check("ready_cal_low", 32'(m.cmd_req_ready), 32'd0);
        m.ctl_cal_success = 1'b1;
        tick();
        check("ready_cal_high", 32'(m.cmd_req_ready), 32'd1);
        m.ctl_cal_success = 1'b0;
        tick();
        check("ready_cal_drop_idle", 32'(m.cmd_req_ready), 32'd0);
        m.ctl_cal_success = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run(i, vecs[i]);

`ifdef LPDDR2_MRR_TIMEOUT_EN
        run(9, '{1'b1, 2'b01, 8'h05, 8'h00, 8'h00, 0, 1000, 0, 1'b0, 1'b0, 3, 66, 64, 1'b1, 8'h00, 8'h00});
`endif

        // Reset pulsed during WAIT of an MRW.
        for (int k = 0; k < 20 && !m.cmd_req_ready; k++) tick();
        m.cmd_req_valid = 1'b1;
        m.cmd_req_read = 1'b0;
        m.cmd_req_chip = 2'b01;
        m.cmd_req_ma = 8'h02;
        m.cmd_req_op = 8'h44;
        tick();
        m.cmd_req_valid = 1'b0;
        m.bus_gnt = 1'b1;
        tick();
        tick();
        tick();
        check("wait_bus_req_before_reset", {m.bus_req, m.to_lmr}, {1'b1, 8'h02});
        #2 ctl_reset_n = 1'b0;
        #1 check("reset_mid_wait_outputs", all_out(), 32'd0);
        m.bus_gnt = 1'b0;
        begin
            int nrsp = 0;
            for (int k = 0; k < 3; k++) begin
                tick();
                nrsp += int'(m.cmd_rsp_valid);
            end
            ctl_reset_n = 1'b1;
            for (int k = 0; k < 8; k++) begin
                tick();
                nrsp += int'(m.cmd_rsp_valid);
            end
            check("no_rsp_after_reset", 32'(nrsp), 32'd0);
        end
        run(10, vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
